// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage, instruction ROM and jump LUT.
package fetch_unit_pkg;

  localparam int unsigned PC_W_DEFAULT  = 10;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage handshake bundle: run control in, PC and status out.
// CycleCount exists only when FETCH_CYCLE_COUNT_EN is defined.
interface fetch_unit_if #(
  parameter int unsigned PC_W  = fetch_unit_pkg::PC_W_DEFAULT,
  parameter int unsigned CNT_W = fetch_unit_pkg::CNT_W_DEFAULT
);

  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             BranchEn;
  logic [PC_W-1:0]  Target;
  logic             Ack;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             PcWrap;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] CycleCount;
`endif

  // Testbench / decoder side
  modport master (
    output Start, StartAddr, BranchEn, Target, Ack,
    input  ProgCtr, Running, Done, PcWrap
`ifdef FETCH_CYCLE_COUNT_EN
    , input CycleCount
`endif
  );

  // Fetch unit side
  modport slave (
    input  Start, StartAddr, BranchEn, Target, Ack,
    output ProgCtr, Running, Done, PcWrap
`ifdef FETCH_CYCLE_COUNT_EN
    , output CycleCount
`endif
  );

endinterface

// File: rtl/fetch_cycle_counter.sv
// Saturating up-counter with synchronous clear; counts RUN cycles.
module fetch_cycle_counter #(
  parameter int unsigned CNT_W = fetch_unit_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over enable; stick at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter stage: IDLE/RUN/HALT sequencing around Start/Ack.
// Optional RUN-cycle counter enabled by FETCH_CYCLE_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_unit_if.slave   bus
);

  localparam logic [PC_W-1:0] PC_MAX = '1;

  fetch_state_t    state;
  logic [PC_W-1:0] prog_ctr;
  logic            running;
  logic            done;
  logic            pc_wrap;

  // Run-control FSM; Start overrides everything except Reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      pc_wrap  <= 1'b0;
    end else begin
      pc_wrap <= 1'b0;
      if (bus.Start) begin
        state    <= RUN;
        prog_ctr <= bus.StartAddr;
        running  <= 1'b1;
        done     <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (bus.Ack) begin
              // Done instruction's address stays on the ROM bus
              state   <= HALT;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (bus.BranchEn) begin
              prog_ctr <= bus.Target;
            end else begin
              prog_ctr <= prog_ctr + PC_W'(1);
              pc_wrap  <= (prog_ctr == PC_MAX);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.ProgCtr = prog_ctr;
  assign bus.Running = running;
  assign bus.Done    = done;
  assign bus.PcWrap  = pc_wrap;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_count;

  fetch_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk    (Clk),
    .rst    (Reset),
    .clear  (bus.Start),
    .enable (state == RUN),
    .count  (cycle_count)
  );

  assign bus.CycleCount = cycle_count;
`endif

endmodule
